if_id_skid_reg: RTL
===================

// Module: if_id_skid_reg
// PURPOSE
//   IF/ID pipeline boundary of the 5-stage MIPS core. Captures {PC, instruction} from PC/IM every cycle.
//   Presents them to decode with a valid/stall handshake.
//   A one-entry skid slot lets the decode stall be registered. The registered ready (en_pc) drives the PC enable,
//   which removes the stall -> IM -> PC combinational path.
// PARAMETERS
//   PC_RESET   32'h0000_3000  pc_d value after reset/flush
//   NOP_INSTR  32'h0000_0000  instr_d value when slot is a bubble
//   IM_BASE    32'h0000_3000  lowest legal fetch address (exception option only)
//   IM_TOP     32'h0000_6FFC  highest legal fetch address (exception option only)
// PORTS
//   clk        in   1   clock, rising edge
//   reset      in   1   synchronous, active-high
//   pc_f       in   32  PC of fetched instruction
//   instr_f    in   32  IM read data for pc_f
//   valid_f    in   1   pc_f/instr_f hold a real instruction
//   stall_d    in   1   decode cannot consume this cycle (hazard unit)
//   flush      in   1   discard all held instructions (exception/eret)
//   en_pc      out  1   registered ready to fetch; ANDed into PC enable
//   pc_d       out  32  PC of instruction in decode
//   instr_d    out  32  instruction in decode
//   valid_d    out  1   pc_d/instr_d valid
//   exc_d      out  5   fetch exception code (only with IF_ID_EXC_EN)
// BEHAVIOUR
//   - Reset (sync, wins over everything): state EMPTY, en_pc=1, valid_d=0, pc_d=PC_RESET, instr_d=NOP_INSTR, skid cleared.
//   - Definitions: accept = valid_f & en_pc; take = valid_d & ~stall_d.
//   - State machine: EMPTY (main empty), RUN (main valid, skid empty), FULL (main+skid valid).
//     EMPTY: accept -> main<=in, RUN; else stay.
//     RUN:   accept&take -> main<=in, stay RUN; accept&~take -> skid<=in, FULL;
//            ~accept&take -> EMPTY (valid_d<=0, instr_d<=NOP_INSTR, pc_d holds); else hold.
//     FULL:  en_pc=0 so accept=0; take -> main<=skid, RUN; else hold both.
//   - en_pc is a flop: en_pc <= (next_state != FULL). Never combinational from stall_d.
//   - Latency: 1 cycle fetch->decode when not stalled. Max 2 instructions held. No loss or duplication under any stall pattern.
//   - Order: skid content always older than any later fetch. Main is drained before skid is promoted.
//   - flush (priority over stall_d and accept): next state EMPTY, en_pc<=1, valid_d<=0, instr_d<=NOP_INSTR,
//     pc_d<=PC_RESET, skid dropped. Fetch presented in the flush cycle is discarded.
//   - Delay slot is not special here. Branch/jump resolution redirects the PC only and never flushes this stage.
// CONFIGURATION
//   IF_IF_EXC_EN: not used; macro is IF_ID_EXC_EN.
//   IF_ID_EXC_EN defined: exc_d present. On accept, if pc_f[1:0]!=0 or pc_f<IM_BASE or pc_f>IM_TOP:
//     exc_d=5'd4 (AdEL) and the stored instruction is NOP_INSTR; otherwise exc_d=0.
//     exc_d travels with the entry through the skid. Reset/flush/bubble -> exc_d=0.
//   IF_ID_EXC_EN undefined: exc_d port absent, no address check, instr_f passed unmodified.
// STRUCTURE
//   - constants.v holds PC_RESET/NOP macros, `EXC_ADEL (5'd4) and 2-bit state encodings `IFID_EMPTY/`IFID_RUN/`IFID_FULL.
//   - One sub-module if_id_slot: 64/69-bit entry register with load/clear, instantiated twice (main, skid).
//   - FSM, en_pc flop and optional address checker live in the top.
// TESTING
//   1 reset 3 cycles -> en_pc=1, valid_d=0, pc_d=32'h3000, instr_d=0.
//   2 stream 0x3000..0x300C, stall_d=0 -> each pc_d one cycle after fetch, valid_d=1 continuously.
//   3 stall_d=1 in the cycle 0x3004 is in decode, 0x3008 fetched -> FULL, en_pc=0 next cycle.
//     Release -> 0x3004, 0x3008, 0x300C in order, none lost or repeated.
//   4 flush while FULL with stall_d=1 -> next cycle valid_d=0, instr_d=0, pc_d=32'h3000, en_pc=1.
//   5 valid_f=0 for 2 cycles mid-stream -> bubble: valid_d=0, instr_d=0, pc_d held.
//   6 IF_ID_EXC_EN: pc_f=32'h3002 -> exc_d=4, instr_d=0; pc_f=32'h7000 -> exc_d=4; pc_f=32'h3008 -> exc_d=0.

Source files
------------

// File: rtl/if_id_skid_reg_pkg.sv
// Shared constants and types for the IF/ID skid register.
// Optional fetch-exception support is selected by IF_ID_EXC_EN.
package if_id_skid_reg_pkg;

    localparam logic [31:0] PC_RESET_DEFAULT  = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] IM_BASE_DEFAULT   = 32'h0000_3000;
    localparam logic [31:0] IM_TOP_DEFAULT    = 32'h0000_6FFC;

    localparam logic [4:0]  EXC_ADEL = 5'd4;

`ifdef IF_ID_EXC_EN
    // Entry layout: {pc[31:0], instr[31:0], exc[4:0]}
    localparam int unsigned ENTRY_W = 69;
`else
    // Entry layout: {pc[31:0], instr[31:0]}
    localparam int unsigned ENTRY_W = 64;
`endif

    typedef enum logic [1:0] {
        IFID_EMPTY = 2'd0,
        IFID_RUN   = 2'd1,
        IFID_FULL  = 2'd2
    } ifid_state_e;

    // True when a fetch address is misaligned or outside instruction memory.
    function automatic logic fetch_addr_bad(input logic [31:0] pc,
                                            input logic [31:0] base,
                                            input logic [31:0] top);
        return (pc[1:0] != 2'b00) || (pc < base) || (pc > top);
    endfunction

endpackage

// File: rtl/if_id_slot.sv
// One IF/ID entry register with synchronous reset, clear and load.
module if_id_slot #(
    parameter int unsigned       W       = 64,
    parameter logic [W-1:0]      RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear_i,
    input  logic         load_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] entry_q;

    // Reset/clear return the slot to its bubble value; load captures a new entry.
    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            entry_q <= RST_VAL;
        end else if (load_i) begin
            entry_q <= d_i;
        end
    end

    assign q_o = entry_q;

endmodule

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with a one-entry skid slot and registered fetch ready.
// Define IF_ID_EXC_EN to add the fetch address check and the exc_d port.
module if_id_skid_reg
    import if_id_skid_reg_pkg::*;
#(
    parameter logic [31:0] PC_RESET  = PC_RESET_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
`ifdef IF_ID_EXC_EN
   ,parameter logic [31:0] IM_BASE   = IM_BASE_DEFAULT,
    parameter logic [31:0] IM_TOP    = IM_TOP_DEFAULT
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_f,
    input  logic [31:0] instr_f,
    input  logic        valid_f,
    input  logic        stall_d,
    input  logic        flush,
    output logic        en_pc,
    output logic [31:0] pc_d,
    output logic [31:0] instr_d,
    output logic        valid_d
`ifdef IF_ID_EXC_EN
   ,output logic [4:0]  exc_d
`endif
);

`ifdef IF_ID_EXC_EN
    localparam logic [ENTRY_W-1:0] RST_ENTRY = {PC_RESET, NOP_INSTR, 5'd0};
`else
    localparam logic [ENTRY_W-1:0] RST_ENTRY = {PC_RESET, NOP_INSTR};
`endif

    ifid_state_e        state_q, state_d;
    logic               en_pc_q;
    logic               accept, take;
    logic               main_load, main_clr, skid_load, skid_clr;
    logic [ENTRY_W-1:0] in_entry, bubble_entry, main_nxt;
    logic [ENTRY_W-1:0] main_q, skid_q;

    assign valid_d = (state_q != IFID_EMPTY);
    assign en_pc   = en_pc_q;
    assign accept  = valid_f & en_pc_q;
    assign take    = valid_d & ~stall_d;

`ifdef IF_ID_EXC_EN
    logic addr_bad;

    // Faulting fetches carry AdEL and a NOP so decode never sees the bad word.
    always_comb begin
        addr_bad     = fetch_addr_bad(pc_f, IM_BASE, IM_TOP);
        in_entry     = {pc_f, (addr_bad ? NOP_INSTR : instr_f), (addr_bad ? EXC_ADEL : 5'd0)};
        bubble_entry = {main_q[68:37], NOP_INSTR, 5'd0};
    end

    assign pc_d    = main_q[68:37];
    assign instr_d = main_q[36:5];
    assign exc_d   = main_q[4:0];
`else
    // Without the exception option the fetched word passes through untouched.
    always_comb begin
        in_entry     = {pc_f, instr_f};
        bubble_entry = {main_q[63:32], NOP_INSTR};
    end

    assign pc_d    = main_q[63:32];
    assign instr_d = main_q[31:0];
`endif

    // State register and registered fetch-ready (low only while both slots are held).
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IFID_EMPTY;
            en_pc_q <= 1'b1;
        end else begin
            state_q <= state_d;
            en_pc_q <= (state_d != IFID_FULL);
        end
    end

    // Next-state and slot control; flush overrides stall and accept.
    always_comb begin
        state_d   = state_q;
        main_load = 1'b0;
        main_clr  = 1'b0;
        skid_load = 1'b0;
        skid_clr  = 1'b0;
        main_nxt  = in_entry;
        if (flush) begin
            state_d  = IFID_EMPTY;
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            case (state_q)
                IFID_EMPTY: begin
                    if (accept) begin
                        main_load = 1'b1;
                        state_d   = IFID_RUN;
                    end
                end
                IFID_RUN: begin
                    if (accept && take) begin
                        main_load = 1'b1;
                    end else if (accept) begin
                        skid_load = 1'b1;
                        state_d   = IFID_FULL;
                    end else if (take) begin
                        // Drained with nothing new: leave a NOP bubble, keep the PC.
                        main_load = 1'b1;
                        main_nxt  = bubble_entry;
                        state_d   = IFID_EMPTY;
                    end
                end
                IFID_FULL: begin
                    if (take) begin
                        main_load = 1'b1;
                        main_nxt  = skid_q;
                        state_d   = IFID_RUN;
                    end
                end
                default: begin
                    state_d  = IFID_EMPTY;
                    main_clr = 1'b1;
                    skid_clr = 1'b1;
                end
            endcase
        end
    end

    if_id_slot #(
        .W       (ENTRY_W),
        .RST_VAL (RST_ENTRY)
    ) u_main (
        .clk     (clk),
        .reset   (reset),
        .clear_i (main_clr),
        .load_i  (main_load),
        .d_i     (main_nxt),
        .q_o     (main_q)
    );

    if_id_slot #(
        .W       (ENTRY_W),
        .RST_VAL (RST_ENTRY)
    ) u_skid (
        .clk     (clk),
        .reset   (reset),
        .clear_i (skid_clr),
        .load_i  (skid_load),
        .d_i     (in_entry),
        .q_o     (skid_q)
    );

endmodule
